// File: rtl/sh7604_membridge_if.sv
// sh7604_membridge_if
// Groups the SH7604 external bus (CPU side) and the simple request/ack
// memory port that sh7604_membridge translates between.
//   CPU side   : cpu_a, cpu_do, bs_n, cs_n, rd_wr_n, we_n -> bridge
//                cpu_di, wait_n                          <- bridge
//   Memory side: mem_a, mem_do, mem_be, mem_wr, mem_area,
//                mem_req, timeout                         <- bridge
//                mem_di, mem_ack                          -> bridge
// Modports:
//   slave  - the bridge's view (it is the CPU's bus slave)
//   master - the environment's view (CPU plus memory model)
interface sh7604_membridge_if;
    logic [26:0] cpu_a;
    logic [31:0] cpu_do;
    logic        bs_n;
    logic [3:0]  cs_n;
    logic        rd_wr_n;
    logic [3:0]  we_n;
    logic [31:0] cpu_di;
    logic        wait_n;
    logic [26:0] mem_a;
    logic [31:0] mem_do;
    logic [3:0]  mem_be;
    logic        mem_wr;
    logic [1:0]  mem_area;
    logic        mem_req;
    logic [31:0] mem_di;
    logic        mem_ack;
    logic        timeout;

    modport slave (
        input  cpu_a, cpu_do, bs_n, cs_n, rd_wr_n, we_n, mem_di, mem_ack,
        output cpu_di, wait_n, mem_a, mem_do, mem_be, mem_wr, mem_area,
               mem_req, timeout
    );

    modport master (
        output cpu_a, cpu_do, bs_n, cs_n, rd_wr_n, we_n, mem_di, mem_ack,
        input  cpu_di, wait_n, mem_a, mem_do, mem_be, mem_wr, mem_area,
               mem_req, timeout
    );
endinterface

// File: rtl/sh7604_membridge.sv
// sh7604_membridge
// Bridges SH7604 external bus cycles on the served chip-select areas onto a
// level request / one-cycle ack memory port. A bus cycle is captured in the
// start cycle, held as MEM_REQ until the memory acks, and the CPU is stalled
// through WAIT_N until the data phase completes.
// Ports:
//   clk_i   - single clock, rising edge
//   rst_i   - synchronous active-high reset
//   ce_r_i  - clock enable; all state advances only when high
//   bus     - sh7604_membridge_if.slave (CPU bus + memory port)
// Parameters:
//   TIMEOUT_CYC - REQ cycles allowed before giving up (1..255)
//   AREA_MASK   - bit n set: area CSn is served here
// Build option:
//   MEMBRIDGE_TIMEOUT_EN - when defined, an 8-bit counter aborts an access
//   that is not acked within TIMEOUT_CYC REQ cycles (reads return all ones,
//   TIMEOUT pulses). When undefined, REQ waits forever and TIMEOUT is 0.
module sh7604_membridge #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [3:0]  AREA_MASK   = 4'b1111
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_r_i,
    sh7604_membridge_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Out-of-range timeout settings are rejected at elaboration.
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout
        $error("sh7604_membridge: TIMEOUT_CYC must be 1..255");
    end

    // {hit, index}: lowest-numbered selected chip select that is served.
    function automatic logic [2:0] area_sel(input logic [3:0] cs_n);
        logic [3:0] cand;
        cand = ~cs_n & AREA_MASK;
        casez (cand)
            4'b???1: area_sel = 3'b100;
            4'b??10: area_sel = 3'b101;
            4'b?100: area_sel = 3'b110;
            4'b1000: area_sel = 3'b111;
            default: area_sel = 3'b000;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [26:0] mem_a_q, mem_a_d;
    logic [31:0] mem_do_q, mem_do_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        mem_wr_q, mem_wr_d;
    logic [1:0]  mem_area_q, mem_area_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] di_q, di_d;
    logic [2:0]  sel_s;
    logic        start_s;
`ifdef MEMBRIDGE_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);
    logic [7:0]  cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    assign sel_s   = area_sel(bus.cs_n);
    assign start_s = (state_q == ST_IDLE) && ce_r_i && !bus.bs_n && sel_s[2];

    // Next-state and datapath capture for the IDLE/REQ/DONE sequencer.
    always_comb begin
        state_d    = state_q;
        mem_a_d    = mem_a_q;
        mem_do_d   = mem_do_q;
        mem_be_d   = mem_be_q;
        mem_wr_d   = mem_wr_q;
        mem_area_d = mem_area_q;
        mem_req_d  = mem_req_q;
        di_d       = di_q;
`ifdef MEMBRIDGE_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    mem_a_d    = bus.cpu_a;
                    mem_do_d   = bus.cpu_do;
                    mem_wr_d   = ~bus.rd_wr_n;
                    mem_be_d   = bus.rd_wr_n ? 4'b1111 : ~bus.we_n;
                    mem_area_d = sel_s[1:0];
                    mem_req_d  = 1'b1;
                    state_d    = ST_REQ;
`ifdef MEMBRIDGE_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Ack has priority over an expiring timeout in the same cycle.
                if (mem_req_q && bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    di_d      = mem_wr_q ? di_q : bus.mem_di;
                    state_d   = ST_DONE;
                end else begin
`ifdef MEMBRIDGE_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO_LIM) begin
                        mem_req_d = 1'b0;
                        di_d      = mem_wr_q ? di_q : 32'hFFFF_FFFF;
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_DONE: begin
                // Leave only once the CPU drops the area select it used.
                if (bus.cs_n[mem_area_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; everything holds while ce_r_i is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            mem_a_q    <= 27'd0;
            mem_do_q   <= 32'd0;
            mem_be_q   <= 4'd0;
            mem_wr_q   <= 1'b0;
            mem_area_q <= 2'd0;
            mem_req_q  <= 1'b0;
            di_q       <= 32'd0;
`ifdef MEMBRIDGE_TIMEOUT_EN
            cnt_q      <= 8'd0;
            timeout_q  <= 1'b0;
`endif
        end else if (ce_r_i) begin
            state_q    <= state_d;
            mem_a_q    <= mem_a_d;
            mem_do_q   <= mem_do_d;
            mem_be_q   <= mem_be_d;
            mem_wr_q   <= mem_wr_d;
            mem_area_q <= mem_area_d;
            mem_req_q  <= mem_req_d;
            di_q       <= di_d;
`ifdef MEMBRIDGE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    // WAIT_N must drop in the very start cycle, so it is decoded from inputs.
    assign bus.wait_n   = ~(start_s || (state_q == ST_REQ));
    assign bus.cpu_di   = di_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_do   = mem_do_q;
    assign bus.mem_be   = mem_be_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_area = mem_area_q;
    assign bus.mem_req  = mem_req_q;
`ifdef MEMBRIDGE_TIMEOUT_EN
    assign bus.timeout  = timeout_q;
`else
    assign bus.timeout  = 1'b0;
`endif

endmodule

// File: doc/sh7604_membridge.md
SH7604_MEMBRIDGE -- requirements
Module: sh7604_membridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum CE_R cycles spent waiting for MEM_ACK (1..255).
REQ-002 Parameter AREA_MASK, default 4'b1111: bit n set means area CSn is served by this block.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 CE_R  in  1  clock enable; state advances only when high.
REQ-006 A  in  27  CPU external address.
REQ-007 DO  in  32  CPU write data.
REQ-008 BS_N  in  1  bus cycle start strobe, active-low.
REQ-009 CS_N  in  4  area chip selects CS3_N..CS0_N, active-low.
REQ-010 RD_WR_N  in  1  1=read, 0=write.
REQ-011 WE_N  in  4  byte write strobes, active-low; bit 3 = DO[31:24].
REQ-012 DI  out  32  registered read data to CPU.
REQ-013 WAIT_N  out  1  wait request to CPU, active-low.
REQ-014 MEM_A  out  27  latched address.
REQ-015 MEM_DO  out  32  latched write data.
REQ-016 MEM_BE  out  4  byte enables, active-high.
REQ-017 MEM_WR  out  1  1=write request.
REQ-018 MEM_AREA  out  2  index of the selected CS.
REQ-019 MEM_REQ  out  1  request, level, held until accepted ack.
REQ-020 MEM_DI  in  32  memory read data, valid with MEM_ACK.
REQ-021 MEM_ACK  in  1  one-cycle completion strobe.
REQ-022 TIMEOUT  out  1  one-cycle pulse on timed-out access.

Function
REQ-023 States: IDLE, REQ, DONE; no other states.
REQ-024 Start condition: state IDLE, CE_R=1, BS_N=0, and a CS_N bit n low with AREA_MASK[n]=1; lowest such n wins.
REQ-025 On start: latch A, DO, RD_WR_N, n into MEM_A, MEM_DO, MEM_WR=~RD_WR_N, MEM_AREA; MEM_BE=~WE_N for writes, 4'b1111 for reads; enter REQ; MEM_REQ=1 from next cycle.
REQ-026 WAIT_N SHALL be 0 combinationally in the start cycle and in every REQ cycle; 1 in IDLE (non-start) and DONE.
REQ-027 MEM_ACK is ignored unless state is REQ and MEM_REQ=1; ack in the start cycle is ignored.
REQ-028 In REQ with MEM_ACK=1: MEM_REQ=0, DI<=MEM_DI if read (DI unchanged on write), enter DONE; latency start-to-DONE is 2 CE_R cycles minimum.
REQ-029 DONE: hold DI and outputs; return to IDLE when CS_N[MEM_AREA]=1; a new start is not accepted in the same cycle.
REQ-030 MEM_A/MEM_DO/MEM_BE/MEM_WR/MEM_AREA SHALL remain stable from start until DONE exit.
REQ-031 Unmasked areas and BS_N=0 with no CS_N low produce no request and WAIT_N=1.
REQ-032 With CE_R=0 all registers hold, including the timeout counter.

Reset
REQ-033 RST=1 on a rising edge forces IDLE, MEM_REQ=0, TIMEOUT=0, WAIT_N=1, DI=0, MEM_A=0, MEM_DO=0, MEM_BE=0, MEM_WR=0, MEM_AREA=0, counter=0, regardless of CE_R.
REQ-034 RST mid-access abandons it; a MEM_ACK arriving afterwards is ignored.

Configuration
REQ-035 Macro MEMBRIDGE_TIMEOUT_EN defined: 8-bit counter cleared on start, increments each CE_R cycle in REQ; when counter reaches TIMEOUT_CYC without ack, MEM_REQ=0, DI=32'hFFFFFFFF for reads, TIMEOUT pulses 1 cycle, state DONE.
REQ-036 Ack and timeout in the same cycle: ack wins, no TIMEOUT pulse.
REQ-037 Macro undefined: no counter, TIMEOUT tied 0, REQ waits indefinitely.

Verification
REQ-038 Read CS0, A=27'h0001234, MEM_ACK 3 cycles after MEM_REQ with MEM_DI=32'hDEADBEEF -> MEM_BE=4'hF, MEM_WR=0, WAIT_N low 4 cycles, DI=32'hDEADBEEF in DONE.
REQ-039 Write CS2, DO=32'h11223344, WE_N=4'b1100 -> MEM_BE=4'b0011, MEM_WR=1, MEM_AREA=2, DI unchanged.
REQ-040 AREA_MASK=4'b0001, cycle on CS3 -> MEM_REQ stays 0, WAIT_N stays 1.
REQ-041 RST asserted while in REQ, then MEM_ACK -> IDLE, MEM_REQ=0, WAIT_N=1, DI=0, no DONE.
REQ-042 MEMBRIDGE_TIMEOUT_EN, TIMEOUT_CYC=4, no ack on read -> TIMEOUT pulse, DI=32'hFFFFFFFF, WAIT_N=1 after 4 REQ cycles.
REQ-043 CS_N held low 5 cycles after ack -> DONE held, no second MEM_REQ until CS_N high and a new BS_N.
